uctl_dma_tx_burst: RTL and testbench
====================================

UCTL_DMA_TX_BURST -- requirements
Module: uctl_dmaTxBurst

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CNTR_WD 20: byte-counter width.
  DATA_SIZE 32: data width; 32, 64 or 128 only; BYTES = DATA_SIZE/8.
  ADDR_SIZE 32: address width.
  MAX_CHUNK 512: max bytes per AHB request; power of two; multiple of BYTES.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
  core_Clk in 1: clock.
  uctl_reset in 1: sync active-high reset.
  sw_rst in 1: sync soft reset.
  sept2dmaTx_dmaStart in 1: start pulse.
  sept2dmaTx_len in CNTR_WD: total bytes.
  sept2dmaTx_sRdAddr in ADDR_SIZE: system start address.
  sept2dmaTx_addrIn in ADDR_SIZE: local start address.
  sept2dmaTx_epStartAddr in ADDR_SIZE: endpoint buffer first word.
  sept2dmaTx_epEndAddr in ADDR_SIZE: endpoint buffer last word (inclusive).
  sept2dmaTx_sRdWr in 1: passed through.
  sept2dmaTx_abort in 1: abort request.
  dmaTx2sept_dn out 1: done pulse.
  dmaTx2sept_aborted out 1: abort-complete pulse.
  dmaTx2ahbm_stransEn out 1: chunk request pulse.
  dmaTx2ahbm_sRdAddr out ADDR_SIZE: chunk system address.
  dmaTx2ahbm_len out CNTR_WD: chunk bytes.
  dmaTx2ahbm_sRdWr out 1: equals sept2dmaTx_sRdWr.
  ahbm2dmaTx_dataDn in 1: chunk fetch complete.
  ahbm2dmaTx_ready in 1: FIFO word available.
  ahbm2dmaTx_wrData in DATA_SIZE: FIFO data.
  dmaTx2ahbm_rd out 1: FIFO pop.
  dmaTx2mif_wrReq out 1: local write request.
  dmaTx2mif_wrAddr out ADDR_SIZE: local address.
  dmaTx2mif_wrData out DATA_SIZE: equals ahbm2dmaTx_wrData.
  dmaTx2mif_wrBe out BYTES: byte enables.
  mif2dmaTx_ack in 1: write accepted.

Function
REQ-004 States: IDLE, REQ, TRANS, ABORT. Registers: sysAddr, memAddr, remReq (bytes not yet requested), remMem (bytes not yet written), chunkRem (bytes left in current chunk), dnSeen flag.
REQ-005 IDLE, dmaStart, len==0: dmaTx2sept_dn pulses the next cycle; state stays IDLE; no AHB request is issued.
REQ-006 IDLE, dmaStart, len!=0: load sysAddr=sRdAddr, memAddr=addrIn, remReq=remMem=len; go to REQ.
REQ-007 dmaStart SHALL be ignored outside IDLE.
REQ-008 REQ (one cycle):
  - stransEn=1; sRdAddr=sysAddr; len=chunk=min(remReq, MAX_CHUNK).
  - chunkRem=chunk; remReq-=chunk; sysAddr+=chunk; dnSeen=0; go to TRANS.
REQ-009 sRdAddr and len hold their values until the next REQ.
REQ-010 TRANS: wrReq = ahbm2dmaTx_ready && chunkRem!=0 (combinational).
REQ-011 TRANS, on wrReq&&ack (same cycle):
  - rd=1.
  - chunkRem and remMem decrease by min(BYTES, chunkRem), saturating at 0.
  - memAddr advances per REQ-012.
REQ-012 memAddr advance: if memAddr >= epEndAddr, next=epStartAddr; else next=memAddr+BYTES, truncated to ADDR_SIZE.
REQ-013 wrBe is all ones when chunkRem>=BYTES; otherwise only the low chunkRem bits are set.
REQ-014 dataDn sets dnSeen. dataDn may arrive before, with, or after the last write of a chunk.
REQ-015 TRANS exit requires chunkRem==0 and (dnSeen or dataDn):
  - remMem==0: dn pulses one cycle, go to IDLE.
  - otherwise: go to REQ.
REQ-016 abort in REQ or TRANS goes to ABORT.
  - A write acked in the same cycle completes and is counted.
  - abort in REQ suppresses stransEn.
REQ-017 ABORT:
  - wrReq=0; rd=ready (discard).
  - When a chunk is outstanding (issued, dnSeen=0), wait for dataDn, then one further cycle of discard.
  - Then dmaTx2sept_aborted pulses one cycle; go to IDLE.
  - dn is never asserted on an aborted transfer.
REQ-018 abort in IDLE is ignored.

Reset
REQ-019 uctl_reset or sw_rst, each asserted for one clock edge:
  - state=IDLE; all counters, addresses and dnSeen=0.
  - stransEn, rd, wrReq, dn, aborted=0; wrBe=0.
REQ-020 Reset mid-transfer SHALL drop the transfer silently: no dn, no aborted pulse.

Verification
REQ-021 DATA_SIZE=32, len=12, addrIn=0x100, FIFO always ready, ack immediate -> 3 writes at 0x100/0x104/0x108, wrBe=0xF, one stransEn with len=12, dn after dataDn.
REQ-022 len=6 -> writes with wrBe 0xF then 0x3; dn one cycle after both the last ack and dataDn.
REQ-023 MAX_CHUNK=512, len=1300 -> stransEn three times, len 512/512/276, sRdAddr base/+512/+1024; one dn.
REQ-024 epStartAddr=0x200, epEndAddr=0x20C, addrIn=0x208, len=16 -> write addresses 0x208, 0x20C, 0x200, 0x204.
REQ-025 Abort after 2 of 8 words, dataDn 5 cycles later -> FIFO drained, aborted pulse after dataDn, no dn, state IDLE.
REQ-026 len=0 start -> dn pulse only; dmaStart during TRANS has no effect; sw_rst mid-TRANS -> IDLE with all outputs 0.

Source files
------------

// File: rtl/uctl_dma_tx_burst.sv
// Transmit DMA burst engine: splits a transfer into AHB chunk requests and
// streams the returned FIFO words into local memory with ring-buffer wrap.
module uctl_dma_tx_burst #(
   parameter int unsigned CNTR_WD   = 20,
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned ADDR_SIZE = 32,
   parameter int unsigned MAX_CHUNK = 512
) (
   input  logic                   core_Clk,
   input  logic                   uctl_reset,
   input  logic                   sw_rst,
   input  logic                   sept2dmaTx_dmaStart,
   input  logic [CNTR_WD-1:0]     sept2dmaTx_len,
   input  logic [ADDR_SIZE-1:0]   sept2dmaTx_sRdAddr,
   input  logic [ADDR_SIZE-1:0]   sept2dmaTx_addrIn,
   input  logic [ADDR_SIZE-1:0]   sept2dmaTx_epStartAddr,
   input  logic [ADDR_SIZE-1:0]   sept2dmaTx_epEndAddr,
   input  logic                   sept2dmaTx_sRdWr,
   input  logic                   sept2dmaTx_abort,
   output logic                   dmaTx2sept_dn,
   output logic                   dmaTx2sept_aborted,
   output logic                   dmaTx2ahbm_stransEn,
   output logic [ADDR_SIZE-1:0]   dmaTx2ahbm_sRdAddr,
   output logic [CNTR_WD-1:0]     dmaTx2ahbm_len,
   output logic                   dmaTx2ahbm_sRdWr,
   input  logic                   ahbm2dmaTx_dataDn,
   input  logic                   ahbm2dmaTx_ready,
   input  logic [DATA_SIZE-1:0]   ahbm2dmaTx_wrData,
   output logic                   dmaTx2ahbm_rd,
   output logic                   dmaTx2mif_wrReq,
   output logic [ADDR_SIZE-1:0]   dmaTx2mif_wrAddr,
   output logic [DATA_SIZE-1:0]   dmaTx2mif_wrData,
   output logic [DATA_SIZE/8-1:0] dmaTx2mif_wrBe,
   input  logic                   mif2dmaTx_ack
);

   localparam int unsigned BYTES = DATA_SIZE / 8;
   localparam logic [CNTR_WD-1:0] BYTES_C = CNTR_WD'(BYTES);
   localparam logic [CNTR_WD-1:0] CHUNK_C = CNTR_WD'(MAX_CHUNK);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_TRANS, ST_ABORT} state_t;

   state_t               state;
   logic [ADDR_SIZE-1:0] sys_addr;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [CNTR_WD-1:0]   rem_req;
   logic [CNTR_WD-1:0]   rem_mem;
   logic [CNTR_WD-1:0]   chunk_rem;
   logic                 dn_seen;

   logic                 is_trans;
   logic                 wr_fire;
   logic [CNTR_WD-1:0]   chunk;
   logic [CNTR_WD-1:0]   dec;
   logic [CNTR_WD-1:0]   chunk_rem_nx;
   logic [CNTR_WD-1:0]   rem_mem_nx;
   logic [ADDR_SIZE-1:0] mem_addr_nx;
   logic                 chunk_done;

   assign is_trans         = (state == ST_TRANS);
   assign dmaTx2mif_wrReq  = is_trans && ahbm2dmaTx_ready && (chunk_rem != '0);
   assign wr_fire          = dmaTx2mif_wrReq && mif2dmaTx_ack;
   assign dmaTx2ahbm_rd    = wr_fire || ((state == ST_ABORT) && ahbm2dmaTx_ready);
   assign dmaTx2mif_wrAddr = mem_addr;
   assign dmaTx2mif_wrData = ahbm2dmaTx_wrData;
   assign dmaTx2ahbm_sRdWr = sept2dmaTx_sRdWr;

   assign chunk        = (rem_req < CHUNK_C) ? rem_req : CHUNK_C;
   assign dec          = (chunk_rem < BYTES_C) ? chunk_rem : BYTES_C;
   assign chunk_rem_nx = wr_fire ? (chunk_rem - dec) : chunk_rem;
   assign rem_mem_nx   = !wr_fire ? rem_mem : ((rem_mem > dec) ? (rem_mem - dec) : '0);
   assign mem_addr_nx  = (mem_addr >= sept2dmaTx_epEndAddr) ? sept2dmaTx_epStartAddr
                                                            : mem_addr + ADDR_SIZE'(BYTES);
   // Exit looks at post-write counters so dn follows the final ack by one cycle.
   assign chunk_done   = (chunk_rem_nx == '0) && (dn_seen || ahbm2dmaTx_dataDn);

   always_comb begin
      dmaTx2mif_wrBe = '0;
      for (int unsigned i = 0; i < BYTES; i++)
         dmaTx2mif_wrBe[i] = is_trans && (chunk_rem > CNTR_WD'(i));
   end

   always_ff @(posedge core_Clk) begin
      if (uctl_reset || sw_rst) begin
         state               <= ST_IDLE;
         sys_addr            <= '0;
         mem_addr            <= '0;
         rem_req             <= '0;
         rem_mem             <= '0;
         chunk_rem           <= '0;
         dn_seen             <= 1'b0;
         dmaTx2sept_dn       <= 1'b0;
         dmaTx2sept_aborted  <= 1'b0;
         dmaTx2ahbm_stransEn <= 1'b0;
         dmaTx2ahbm_sRdAddr  <= '0;
         dmaTx2ahbm_len      <= '0;
      end else begin
         dmaTx2sept_dn       <= 1'b0;
         dmaTx2sept_aborted  <= 1'b0;
         dmaTx2ahbm_stransEn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sept2dmaTx_dmaStart) begin
                  if (sept2dmaTx_len == '0) begin
                     dmaTx2sept_dn <= 1'b1;
                  end else begin
                     sys_addr <= sept2dmaTx_sRdAddr;
                     mem_addr <= sept2dmaTx_addrIn;
                     rem_req  <= sept2dmaTx_len;
                     rem_mem  <= sept2dmaTx_len;
                     // dn_seen high means no chunk is outstanding on the AHB side.
                     dn_seen  <= 1'b1;
                     state    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (sept2dmaTx_abort) begin
                  state <= ST_ABORT;
               end else begin
                  dmaTx2ahbm_stransEn <= 1'b1;
                  dmaTx2ahbm_sRdAddr  <= sys_addr;
                  dmaTx2ahbm_len      <= chunk;
                  chunk_rem           <= chunk;
                  rem_req             <= rem_req - chunk;
                  sys_addr            <= sys_addr + ADDR_SIZE'(chunk);
                  dn_seen             <= 1'b0;
                  state               <= ST_TRANS;
               end
            end
            ST_TRANS: begin
               chunk_rem <= chunk_rem_nx;
               rem_mem   <= rem_mem_nx;
               if (wr_fire)
                  mem_addr <= mem_addr_nx;
               if (ahbm2dmaTx_dataDn)
                  dn_seen <= 1'b1;
               if (sept2dmaTx_abort) begin
                  state <= ST_ABORT;
               end else if (chunk_done) begin
                  if (rem_mem_nx == '0) begin
                     dmaTx2sept_dn <= 1'b1;
                     state         <= ST_IDLE;
                  end else begin
                     state <= ST_REQ;
                  end
               end
            end
            ST_ABORT: begin
               // Wait out an in-flight chunk, then give one more cycle of FIFO discard.
               if (!dn_seen) begin
                  if (ahbm2dmaTx_dataDn)
                     dn_seen <= 1'b1;
               end else begin
                  dmaTx2sept_aborted <= 1'b1;
                  rem_req            <= '0;
                  rem_mem            <= '0;
                  chunk_rem          <= '0;
                  state              <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uctl_dma_tx_burst.sv
// Directed bench for uctl_dma_tx_burst: linear stimulus, immediate-assertion checks.
module tb_uctl_dma_tx_burst;

   logic        core_Clk = 1'b0;
   logic        uctl_reset, sw_rst;
   logic        start;
   logic [19:0] len;
   logic [31:0] s_addr, addr_in, ep_start, ep_end;
   logic        s_rdwr, abort_r;
   logic        dn, aborted, strans_en;
   logic [31:0] ahb_addr;
   logic [19:0] ahb_len;
   logic        ahb_rdwr;
   logic        data_dn, ready;
   logic [31:0] fifo_data;
   logic        rd, wr_req;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_be;
   logic        ack;

   int n_cmp = 0;
   int n_err = 0;

   int          ns, nw, ndn;
   logic        pend;
   logic [31:0] lg_len  [4];
   logic [31:0] lg_addr [4];

   always #5 core_Clk = ~core_Clk;

   uctl_dma_tx_burst #(
      .CNTR_WD(20), .DATA_SIZE(32), .ADDR_SIZE(32), .MAX_CHUNK(512)
   ) dut (
      .core_Clk(core_Clk), .uctl_reset(uctl_reset), .sw_rst(sw_rst),
      .sept2dmaTx_dmaStart(start), .sept2dmaTx_len(len),
      .sept2dmaTx_sRdAddr(s_addr), .sept2dmaTx_addrIn(addr_in),
      .sept2dmaTx_epStartAddr(ep_start), .sept2dmaTx_epEndAddr(ep_end),
      .sept2dmaTx_sRdWr(s_rdwr), .sept2dmaTx_abort(abort_r),
      .dmaTx2sept_dn(dn), .dmaTx2sept_aborted(aborted),
      .dmaTx2ahbm_stransEn(strans_en), .dmaTx2ahbm_sRdAddr(ahb_addr),
      .dmaTx2ahbm_len(ahb_len), .dmaTx2ahbm_sRdWr(ahb_rdwr),
      .ahbm2dmaTx_dataDn(data_dn), .ahbm2dmaTx_ready(ready),
      .ahbm2dmaTx_wrData(fifo_data), .dmaTx2ahbm_rd(rd),
      .dmaTx2mif_wrReq(wr_req), .dmaTx2mif_wrAddr(wr_addr),
      .dmaTx2mif_wrData(wr_data), .dmaTx2mif_wrBe(wr_be),
      .mif2dmaTx_ack(ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge core_Clk);
      #1;
   endtask

   task automatic kick(input logic [19:0] l, input logic [31:0] sa, input logic [31:0] ai);
      nxt();
      start   = 1'b1;
      len     = l;
      s_addr  = sa;
      addr_in = ai;
   endtask

   initial begin
      uctl_reset = 1'b1; sw_rst = 1'b0; start = 1'b0; len = '0;
      s_addr = '0; addr_in = '0; ep_start = '0; ep_end = 32'hFFFF_FFFF;
      s_rdwr = 1'b1; abort_r = 1'b0; data_dn = 1'b0; ready = 1'b1;
      fifo_data = 32'hCAFE_F00D; ack = 1'b1;
      nxt(); nxt();
      uctl_reset = 1'b0;
      #1;
      chk("rst_strans", strans_en, 0);
      chk("rst_wrreq",  wr_req, 0);
      chk("rst_rd",     rd, 0);
      chk("rst_wrbe",   wr_be, 0);
      chk("rst_dn",     dn, 0);
      chk("rst_abt",    aborted, 0);
      chk("rdwr_pass",  ahb_rdwr, 1);

      // len=12, three full words
      kick(20'd12, 32'h8000, 32'h100);
      nxt(); start = 1'b0; #1;
      chk("t1_strans_c1", strans_en, 0);
      nxt(); #1;
      chk("t1_strans", strans_en, 1);
      chk("t1_saddr",  ahb_addr, 32'h8000);
      chk("t1_len",    ahb_len, 12);
      chk("t1_wr0",    wr_addr, 32'h100);
      chk("t1_be0",    wr_be, 4'hF);
      chk("t1_rd0",    rd, 1);
      chk("t1_data",   wr_data, 32'hCAFE_F00D);
      nxt(); #1;
      chk("t1_strans_once", strans_en, 0);
      chk("t1_wr1", wr_addr, 32'h104);
      nxt(); #1;
      chk("t1_wr2", wr_addr, 32'h108);
      chk("t1_be2", wr_be, 4'hF);
      nxt(); data_dn = 1'b1; #1;
      chk("t1_wrreq_end", wr_req, 0);
      chk("t1_dn_early",  dn, 0);
      nxt(); data_dn = 1'b0; #1;
      chk("t1_dn",        dn, 1);
      chk("t1_hold_addr", ahb_addr, 32'h8000);
      chk("t1_hold_len",  ahb_len, 12);
      nxt(); #1;
      chk("t1_dn_pulse",  dn, 0);

      // len=6, partial last word, dataDn before the last write
      kick(20'd6, 32'h0, 32'h40);
      nxt(); start = 1'b0;
      nxt(); data_dn = 1'b1; #1;
      chk("t2_wr0", wr_addr, 32'h40);
      chk("t2_be0", wr_be, 4'hF);
      nxt(); data_dn = 1'b0; #1;
      chk("t2_wr1",  wr_addr, 32'h44);
      chk("t2_be1",  wr_be, 4'h3);
      chk("t2_req1", wr_req, 1);
      chk("t2_dn0",  dn, 0);
      nxt(); #1;
      chk("t2_dn",    dn, 1);
      chk("t2_noreq", wr_req, 0);

      // len=1300, three chunks
      kick(20'd1300, 32'h10000, 32'h0);
      nxt(); start = 1'b0;
      ns = 0; nw = 0; ndn = 0; pend = 1'b0;
      for (int c = 0; c < 600 && ndn == 0; c++) begin
         nxt();
         data_dn = pend;
         pend = 1'b0;
         #1;
         if (strans_en) begin
            if (ns < 4) begin
               lg_len[ns]  = 32'(ahb_len);
               lg_addr[ns] = ahb_addr;
            end
            ns++;
            pend = 1'b1;
         end
         if (wr_req && ack) nw++;
         if (dn) ndn++;
      end
      data_dn = 1'b0;
      chk("t3_dn_count", ndn, 1);
      chk("t3_nstrans",  ns, 3);
      chk("t3_len0",  lg_len[0], 512);
      chk("t3_len1",  lg_len[1], 512);
      chk("t3_len2",  lg_len[2], 276);
      chk("t3_addr0", lg_addr[0], 32'h10000);
      chk("t3_addr1", lg_addr[1], 32'h10200);
      chk("t3_addr2", lg_addr[2], 32'h10400);
      chk("t3_writes", nw, 325);
      nxt(); #1;
      chk("t3_dn_pulse", dn, 0);

      // ring-buffer wrap
      ep_start = 32'h200; ep_end = 32'h20C;
      kick(20'd16, 32'h0, 32'h208);
      nxt(); start = 1'b0;
      nxt(); data_dn = 1'b1; #1;
      chk("t4_wr0", wr_addr, 32'h208);
      nxt(); data_dn = 1'b0; #1;
      chk("t4_wr1", wr_addr, 32'h20C);
      nxt(); #1;
      chk("t4_wr2", wr_addr, 32'h200);
      nxt(); #1;
      chk("t4_wr3", wr_addr, 32'h204);
      nxt(); #1;
      chk("t4_dn", dn, 1);
      ep_start = '0; ep_end = 32'hFFFF_FFFF;

      // abort after two of eight words, dataDn five cycles later
      kick(20'd32, 32'h0, 32'h500);
      nxt(); start = 1'b0;
      nxt(); #1;
      chk("t5_wr0", wr_addr, 32'h500);
      nxt(); abort_r = 1'b1; #1;
      chk("t5_wr1",  wr_addr, 32'h504);
      chk("t5_rd1",  rd, 1);
      nxt(); abort_r = 1'b0; ack = 1'b0; #1;
      chk("t5_abt_wrreq", wr_req, 0);
      chk("t5_abt_rd",    rd, 1);
      chk("t5_abt_early", aborted, 0);
      for (int c = 0; c < 3; c++) begin
         nxt(); #1;
         chk("t5_wait_rd",  rd, 1);
         chk("t5_wait_abt", aborted, 0);
         chk("t5_wait_dn",  dn, 0);
      end
      nxt(); data_dn = 1'b1; #1;
      chk("t5_dd_abt", aborted, 0);
      nxt(); data_dn = 1'b0; #1;
      chk("t5_tail_rd",  rd, 1);
      chk("t5_tail_abt", aborted, 0);
      nxt(); #1;
      chk("t5_aborted",  aborted, 1);
      chk("t5_no_dn",    dn, 0);
      chk("t5_idle_rd",  rd, 0);
      nxt(); #1;
      chk("t5_abt_pulse", aborted, 0);
      chk("t5_idle_req",  wr_req, 0);
      ack = 1'b1;

      // zero-length start
      kick(20'd0, 32'h0, 32'h0);
      nxt(); start = 1'b0; #1;
      chk("t6_dn",     dn, 1);
      chk("t6_strans", strans_en, 0);
      nxt(); #1;
      chk("t6_dn_pulse", dn, 0);
      chk("t6_strans2",  strans_en, 0);

      // dmaStart during TRANS is ignored
      ready = 1'b0;
      kick(20'd8, 32'h9000, 32'h300);
      nxt(); start = 1'b0;
      nxt(); #1;
      chk("t7_strans", strans_en, 1);
      chk("t7_noready_req", wr_req, 0);
      nxt(); start = 1'b1; len = 20'd100; s_addr = 32'hA000; addr_in = 32'h700; #1;
      chk("t7_strans_off", strans_en, 0);
      nxt(); start = 1'b0; ready = 1'b1; data_dn = 1'b1; #1;
      chk("t7_wr0", wr_addr, 32'h300);
      chk("t7_strans_ign", strans_en, 0);
      nxt(); data_dn = 1'b0; #1;
      chk("t7_wr1", wr_addr, 32'h304);
      nxt(); #1;
      chk("t7_dn",   dn, 1);
      chk("t7_addr", ahb_addr, 32'h9000);
      chk("t7_len",  ahb_len, 8);
      nxt(); #1;
      chk("t7_no_restart", strans_en, 0);
      nxt(); #1;
      chk("t7_no_restart2", strans_en, 0);

      // soft reset mid-TRANS
      ready = 1'b0;
      kick(20'd16, 32'h4000, 32'h600);
      nxt(); start = 1'b0;
      nxt(); #1;
      chk("t8_strans", strans_en, 1);
      nxt(); sw_rst = 1'b1;
      nxt(); sw_rst = 1'b0; ready = 1'b1; #1;
      chk("t8_wrreq", wr_req, 0);
      chk("t8_rd",    rd, 0);
      chk("t8_wrbe",  wr_be, 0);
      chk("t8_saddr", ahb_addr, 0);
      chk("t8_len",   ahb_len, 0);
      chk("t8_waddr", wr_addr, 0);
      nxt(); data_dn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         nxt(); data_dn = 1'b0; #1;
         chk("t8_no_dn",  dn, 0);
         chk("t8_no_abt", aborted, 0);
         chk("t8_no_req", wr_req, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
